// File: rtl/cpu_pin_bridge.sv
// cpu_pin_bridge: serialises one parallel CPU bus request onto a narrow
// bidirectional pin bus, LSB slice first, then returns a single response.
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready CPU request handshake (ready only in IDLE)
//   req_write           1 = write, 0 = read
//   req_addr/req_wdata  request address and write data
//   resp_valid          one-cycle response pulse
//   resp_rdata/resp_err read data (0 for writes/timeouts) and timeout flag
//   pin_out/pin_oe      pin bus drive value and output enable
//   pin_in              pin bus sampled value
//   pin_strobe          high on every beat cycle (ADDR, CMD, WDATA, RDATA)
//   pin_phase           current state code
//   ext_ready           external device ready
module cpu_pin_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PIN_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  input  logic [PIN_W-1:0]  pin_in,
  output logic              pin_strobe,
  output logic [2:0]        pin_phase,
  input  logic              ext_ready
);

  localparam int AB   = ADDR_W / PIN_W;
  localparam int DB   = DATA_W / PIN_W;
  localparam int MAXB = (AB > DB) ? AB : DB;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PW = PIN_W;

  localparam logic [BW-1:0] A_LAST = BW'(AB - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DB - 1);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_CMD   = 3'd2,
    S_WDATA = 3'd3,
    S_TURN  = 3'd4,
    S_WAIT  = 3'd5,
    S_RDATA = 3'd6,
    S_RESP  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  int unsigned        off_q, off_d;

  logic [PIN_W-1:0]   out_d, oe_d;
  logic               strobe_d, ready_d, rvalid_d, rerr_d;
  logic [DATA_W-1:0]  rrdata_d;

  assign off_q = 32'(beat_q) * PW;
  assign off_d = 32'(beat_d) * PW;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tcnt_d  = tcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          rdata_d = '0;
          err_d   = 1'b0;
          beat_d  = '0;
          tcnt_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (beat_q == A_LAST) begin
          beat_d  = '0;
          state_d = S_CMD;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_CMD: begin
        beat_d  = '0;
        state_d = write_q ? S_WDATA : S_TURN;
      end
      S_WDATA: begin
        if (beat_q == D_LAST) begin
          beat_d  = '0;
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_TURN: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ext_ready) begin
          err_d   = 1'b0;
          beat_d  = '0;
          state_d = write_q ? S_RESP : S_RDATA;
        end else if (TIMEOUT != 0) begin
          // Counter holds completed idle WAIT cycles; the TIMEOUT-th one ends the wait.
          if (tcnt_q == T_LAST) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_RDATA: begin
        rdata_d[off_q +: PIN_W] = pin_in;
        if (beat_q == D_LAST) begin
          beat_d  = '0;
          state_d = S_RESP;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the cycle the FSM actually spends in that state.
  always_comb begin
    out_d    = '0;
    oe_d     = '0;
    strobe_d = 1'b0;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    rrdata_d = resp_rdata;
    rerr_d   = resp_err;
    case (state_d)
      S_IDLE:  ready_d = 1'b1;
      S_ADDR: begin
        out_d    = addr_d[off_d +: PIN_W];
        oe_d     = '1;
        strobe_d = 1'b1;
      end
      S_CMD: begin
        out_d    = PIN_W'(write_d);
        oe_d     = '1;
        strobe_d = 1'b1;
      end
      S_WDATA: begin
        out_d    = wdata_d[off_d +: PIN_W];
        oe_d     = '1;
        strobe_d = 1'b1;
      end
      S_RDATA: strobe_d = 1'b1;
      S_RESP: begin
        rvalid_d = 1'b1;
        rrdata_d = rdata_d;
        rerr_d   = err_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      tcnt_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      pin_out    <= '0;
      pin_oe     <= '0;
      pin_strobe <= 1'b0;
      pin_phase  <= 3'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      tcnt_q     <= tcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      write_q    <= write_d;
      err_q      <= err_d;
      req_ready  <= ready_d;
      resp_valid <= rvalid_d;
      resp_rdata <= rrdata_d;
      resp_err   <= rerr_d;
      pin_out    <= out_d;
      pin_oe     <= oe_d;
      pin_strobe <= strobe_d;
      pin_phase  <= state_d;
    end
  end

endmodule

// File: doc/cpu_pin_bridge.md
Name: cpu_pin_bridge

Overview:
- Parametrised successor to the TinyTapeout CPU pin handler.
- Takes one parallel CPU bus request (address, write data, read/write) and serialises it over a narrow bidirectional pin bus in PIN_W-wide beats, LSB slice first.
- Waits for an external ready with a timeout, captures read data beat by beat, then returns one response to the CPU.
- Sits between the cpu core and the tt_um top-level pins (uo_out / uio_*).

Parameters:
- ADDR_W, 32, address width; must be a multiple of PIN_W.
- DATA_W, 32, data width; must be a multiple of PIN_W.
- PIN_W, 8, pin bus width.
- TIMEOUT, 15, maximum WAIT cycles without ext_ready before an error response; 0 = wait forever.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  bridge can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  read data; 0 for writes.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- pin_out  out  PIN_W  pin bus drive value.
- pin_oe  out  PIN_W  pin output enable, all-ones or all-zeros.
- pin_in  in  PIN_W  pin bus sampled value.
- pin_strobe  out  1  high on every beat cycle (ADDR, CMD, WDATA, RDATA).
- pin_phase  out  3  current FSM state code, for debug/external sequencing.
- ext_ready  in  1  external device ready.

Behaviour:
- Derived counts: AB = ADDR_W/PIN_W, DB = DATA_W/PIN_W. The beat counter and the timeout counter are sized by $clog2.
- State codes (pin_phase): IDLE=0, ADDR=1, CMD=2, WDATA=3, TURN=4, WAIT=5, RDATA=6, RESP=7.
- All outputs are registered. Listed values hold during every cycle the FSM is in that state.
- Reset (async): state IDLE; beat and timeout counters 0; latched request 0. Outputs: req_ready=0 while rst is high, then 1 in IDLE; resp_valid=0, resp_rdata=0, resp_err=0, pin_out=0, pin_oe=0, pin_strobe=0, pin_phase=0.
- Reset mid-transaction drops the transaction; no response is issued.
- IDLE:
  - req_ready=1, pin_oe=0.
  - On req_valid & req_ready: latch addr/wdata/write, clear rdata, go to ADDR with beat=0.
- ADDR:
  - pin_out = addr[beat*PIN_W +: PIN_W], pin_oe=all-ones, strobe=1.
  - Lasts exactly AB cycles, then CMD.
- CMD:
  - pin_out = {0…, write}, pin_oe=all-ones, strobe=1. Lasts 1 cycle.
  - Next state: WDATA if write, else TURN.
- WDATA:
  - pin_out = wdata slice[beat], pin_oe=all-ones, strobe=1.
  - Lasts DB cycles, then WAIT. Every beat carries its own slice; no repeated bytes.
- TURN: pin_oe=0, pin_out=0, strobe=0. Lasts 1 cycle (bus turnaround), then WAIT.
- WAIT:
  - pin_oe=0, strobe=0. ext_ready is sampled each cycle.
  - ext_ready=1: go to RDATA (read) or RESP (write), err=0.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT (TIMEOUT≠0), go to RESP with err=1 and skip RDATA.
  - Waiting with ext_ready low therefore lasts exactly TIMEOUT cycles.
- RDATA:
  - pin_oe=0, strobe=1.
  - pin_in is captured into rdata slice[beat] at the end of each cycle. Lasts DB cycles, then RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_rdata (0 for write or on timeout) and resp_err. Then IDLE.
  - resp_rdata and resp_err hold their values until the next RESP or reset.
- Ordering and request handling:
  - req_valid outside IDLE is ignored; the CPU must hold the request until accepted.
  - Minimum one IDLE cycle between transactions.
  - req_wdata/req_addr changes after acceptance have no effect.
- Latency, defaults, ext_ready high: write resp_valid 11 cycles after the accept edge; read 12 cycles.

Test Plan:
- Reset mid-ADDR: assert rst during beat 2 -> next cycle pin_oe=0, pin_phase=0, no resp_valid ever; req_ready=1 after release.
- Write, ext_ready=1: addr 0x12345678, wdata 0xCAFEBABE -> pin_out beats 78,56,34,12,01,BE,BA,FE,CA with strobe high; resp_valid in cycle 11, resp_err=0, resp_rdata=0.
- Read, ext_ready=1: addr 0x000000A5; drive pin_in EF,BE,AD,DE during RDATA -> beats A5,00,00,00,00; TURN with oe=0; resp_rdata=0xDEADBEEF in cycle 12.
- Wait states: read with ext_ready low 5 WAIT cycles then high -> RDATA starts the following cycle, resp_err=0, total latency 17.
- Timeout: write with ext_ready held 0, TIMEOUT=15 -> 15 WAIT cycles, then resp_valid=1, resp_err=1; next read returns normally with err=0.
- Param sweep: PIN_W=4, ADDR_W=16, DATA_W=8, read addr 0xBEEF -> address beats F,E,E,B; 2 RDATA beats; req_valid held during busy is not double-accepted (exactly one response).
